// File: rtl/compress42_acc_pipe.sv
// Three-stage four-operand adder/accumulator: operand extension, a row of dual-mux
// 4:2 compressors producing sum/carry vectors, then final add into an optional accumulator.
module compress42_acc_pipe #(
    parameter int WIDTH = 8,
    parameter int AW    = WIDTH + 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             cin,
    input  logic             sgn,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    result,
    output logic             ovf
);

    function automatic logic [AW-1:0] extend(input logic [WIDTH-1:0] x, input logic s);
        extend = {{(AW-WIDTH){s & x[WIDTH-1]}}, x};
    endfunction

    function automatic logic add_ovf(input logic [AW-1:0] base, input logic [AW-1:0] t,
                                     input logic [AW-1:0] r, input logic carry_out,
                                     input logic s);
        if (s) add_ovf = (base[AW-1] == t[AW-1]) && (r[AW-1] != base[AW-1]);
        else   add_ovf = carry_out;
    endfunction

    logic adv;

    logic                 v1_q, v1_d;
    logic signed [AW-1:0] a_p1_q, a_p1_d, b_p1_q, b_p1_d, c_p1_q, c_p1_d, d_p1_q, d_p1_d;
    logic                 cin_p1_q, cin_p1_d, sgn_p1_q, sgn_p1_d;
    logic                 en_p1_q, en_p1_d, clr_p1_q, clr_p1_d;

    logic                 v2_q, v2_d;
    logic        [AW-1:0] s_p2_q, s_p2_d;
    logic        [AW-2:0] c_p2_q, c_p2_d;
    logic                 sgn_p2_q, sgn_p2_d, en_p2_q, en_p2_d, clr_p2_q, clr_p2_d;

    logic                 out_valid_q, out_valid_d;
    logic        [AW-1:0] result_q, result_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;

    logic [AW-1:0] x12, xall, cin_vec, sum_vec;
    logic [AW-2:0] cout_vec, carry_vec;
    logic [AW-1:0] t_p3, base_p3, r_p3;
    logic [AW:0]   wide_p3;

    // A single global enable: any held output freezes every stage, bubbles included.
    assign in_ready  = !(out_valid_q && !out_ready);
    assign adv       = in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;

    // ---- S1 -> S2: dual-mux 4:2 row; cout depends only on a/b/c so the ripple is one level deep
    assign x12       = a_p1_q ^ b_p1_q;
    assign xall      = x12 ^ c_p1_q ^ d_p1_q;
    assign cout_vec  = (x12[AW-2:0] & c_p1_q[AW-2:0]) | (~x12[AW-2:0] & a_p1_q[AW-2:0]);
    assign cin_vec   = {cout_vec, cin_p1_q};
    assign sum_vec   = xall ^ cin_vec;
    assign carry_vec = (xall[AW-2:0] & cin_vec[AW-2:0]) | (~xall[AW-2:0] & d_p1_q[AW-2:0]);

    // ---- S2 -> S3: resolve carry-save pair, then optionally accumulate
    assign t_p3    = s_p2_q + {c_p2_q, 1'b0};
    assign base_p3 = clr_p2_q ? '0 : acc_q;
    assign wide_p3 = {1'b0, base_p3} + {1'b0, t_p3};
    assign r_p3    = en_p2_q ? wide_p3[AW-1:0] : t_p3;

    always_comb begin
        v1_d = v1_q;         a_p1_d = a_p1_q;     b_p1_d = b_p1_q;   c_p1_d = c_p1_q;
        d_p1_d = d_p1_q;     cin_p1_d = cin_p1_q; sgn_p1_d = sgn_p1_q;
        en_p1_d = en_p1_q;   clr_p1_d = clr_p1_q;
        v2_d = v2_q;         s_p2_d = s_p2_q;     c_p2_d = c_p2_q;
        sgn_p2_d = sgn_p2_q; en_p2_d = en_p2_q;   clr_p2_d = clr_p2_q;
        out_valid_d = out_valid_q;
        result_d = result_q; acc_d = acc_q;       ovf_d = ovf_q;
        if (adv) begin
            v1_d     = in_valid;
            a_p1_d   = extend(a, sgn);
            b_p1_d   = extend(b, sgn);
            c_p1_d   = extend(c, sgn);
            d_p1_d   = extend(d, sgn);
            cin_p1_d = cin;
            sgn_p1_d = sgn;
            en_p1_d  = acc_en;
            clr_p1_d = acc_clr;

            v2_d     = v1_q;
            s_p2_d   = sum_vec;
            c_p2_d   = carry_vec;
            sgn_p2_d = sgn_p1_q;
            en_p2_d  = en_p1_q;
            clr_p2_d = clr_p1_q;

            out_valid_d = v2_q;
            if (v2_q) begin
                result_d = r_p3;
                acc_d    = en_p2_q ? r_p3 : base_p3;
                ovf_d    = (clr_p2_q ? 1'b0 : ovf_q) |
                           (en_p2_q & add_ovf(base_p3, t_p3, r_p3, wide_p3[AW], sgn_p2_q));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
        end
    end

    // Payload registers are qualified by the valid flags and need no reset.
    always_ff @(posedge clk) begin
        a_p1_q   <= a_p1_d;
        b_p1_q   <= b_p1_d;
        c_p1_q   <= c_p1_d;
        d_p1_q   <= d_p1_d;
        cin_p1_q <= cin_p1_d;
        sgn_p1_q <= sgn_p1_d;
        en_p1_q  <= en_p1_d;
        clr_p1_q <= clr_p1_d;
        s_p2_q   <= s_p2_d;
        c_p2_q   <= c_p2_d;
        sgn_p2_q <= sgn_p2_d;
        en_p2_q  <= en_p2_d;
        clr_p2_q <= clr_p2_d;
    end

endmodule

// File: tb/tb_compress42_acc_pipe.sv
// Randomised and directed bench for compress42_acc_pipe against an integer-arithmetic
// reference model with an in-order queue of expected outputs.
module tb_compress42_acc_pipe;
    localparam int WIDTH = 8;
    localparam int AW    = 16;
    localparam longint MOD = 64'd1 << AW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] a, b, c, d;
    logic             cin, sgn, acc_en, acc_clr;
    logic             out_valid, out_ready;
    logic [AW-1:0]    result;
    logic             ovf;

    compress42_acc_pipe #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .cin(cin), .sgn(sgn),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint res;
        bit     ov;
        int     cyc;
    } exp_t;

    exp_t   q[$];
    longint macc;
    bit     mov;
    int     n_tests, n_fail, cyc;
    bit     rnd_rdy, chk_lat;
    int     stall_from;
    longint last_res;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint to_signed(input longint v);
        return (v >= MOD / 2) ? v - MOD : v;
    endfunction

    function automatic longint ext_op(input logic [WIDTH-1:0] x, input logic s);
        return s ? longint'($signed(x)) : longint'(x);
    endfunction

    // Reference: the sum of four extended operands plus cin, modulo 2^AW, then accumulate.
    function automatic void model_push();
        longint t, base, sum, r;
        bit     o;
        exp_t   e;
        t = ext_op(a, sgn) + ext_op(b, sgn) + ext_op(c, sgn) + ext_op(d, sgn) + longint'(cin);
        t = ((t % MOD) + MOD) % MOD;
        base = acc_clr ? 0 : macc;
        sum  = base + t;
        if (sgn) begin
            o = (to_signed(base) + to_signed(t) > MOD / 2 - 1) ||
                (to_signed(base) + to_signed(t) < -(MOD / 2));
        end else begin
            o = (sum >= MOD);
        end
        r    = acc_en ? sum % MOD : t;
        mov  = acc_clr ? 1'b0 : mov;
        if (acc_en && o) mov = 1'b1;
        macc = acc_en ? r : base;
        e.res = r;
        e.ov  = mov;
        e.cyc = cyc;
        q.push_back(e);
    endfunction

    // One clock: inputs already driven after a negedge; evaluate both handshakes just before the posedge.
    task automatic tick(output bit accepted);
        exp_t e;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        else         out_ready = !(cyc >= stall_from && cyc < stall_from + 2);
        #1;
        check("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                check("result", longint'(result), e.res);
                check("ovf", longint'(ovf), longint'(e.ov));
                if (chk_lat) check("latency", longint'(cyc - e.cyc), 3);
                last_res = longint'(result);
            end
        end
        if (accepted) model_push();
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [WIDTH-1:0] ia, ib, ic, id,
                        input logic icin, isgn, ien, iclr);
        bit acc;
        int n;
        a = ia; b = ib; c = ic; d = id;
        cin = icin; sgn = isgn; acc_en = ien; acc_clr = iclr;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            tick(acc);
            n++;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic drain();
        bit acc;
        int n;
        rnd_rdy = 1'b0;
        in_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            tick(acc);
            n++;
        end
        check("drain_left", longint'(q.size()), 0);
        idle(2);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        macc = 0; mov = 1'b0;
        rnd_rdy = 1'b0; chk_lat = 1'b0; stall_from = -100;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0;
        cin = 1'b0; sgn = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_result", longint'(result), 0);
        check("rst_ovf", longint'(ovf), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        chk_lat = 1'b1;
        send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        check("unsigned_all_ones", last_res, 64'h03FD);
        send(8'h80, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        check("signed_mix", last_res, 64'hFF80);
        chk_lat = 1'b0;

        stall_from = cyc + 3;
        send(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h10, 8'h20, 8'h30, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'hF0, 8'h0F, 8'h55, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h7E, 8'h81, 8'hC3, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        stall_from = -100;
        drain();

        for (int i = 0; i < 10; i++)
            send(8'h64, 8'h64, 8'h64, 8'h64, 1'b0, 1'b0, 1'b1, (i == 0));
        drain();
        check("acc_ten", last_res, 64'h0FA0);
        send(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        check("acc_clr_restart", last_res, 64'h0001);

        for (int i = 0; i < 64; i++)
            send(8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b1, 1'b1, (i == 0));
        send(8'h2C, 8'h2C, 8'h2C, 8'h2C, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        check("acc_at_7ff0", last_res, 64'h7FF0);
        send(8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        check("signed_wrap", last_res, 64'h81EC);
        check("ovf_set", longint'(ovf), 1);
        for (int i = 0; i < 3; i++)
            send(8'(i), 8'h05, 8'hFE, 8'h11, 1'b0, i[0], 1'b0, 1'b0);

        rnd_rdy = 1'b0;
        send(8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0);
        send(8'h55, 8'h66, 8'h77, 8'h88, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'h99, 8'hAA, 8'hBB, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_result", longint'(result), 0);
        check("midrst_ovf", longint'(ovf), 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        q.delete();
        macc = 0;
        mov = 1'b0;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        chk_lat = 1'b1;
        send(8'h03, 8'h04, 8'h05, 8'h06, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("post_reset_sum", last_res, 64'h0013);
        chk_lat = 1'b0;

        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
